// File: rtl/regfile_pkg.sv
// Shared constants, clear-sweep state encoding and write-port arbitration helper.
// Pure declarations; no timing or flow control of its own.
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int MAX_WR       = 8;
  localparam int MAX_AW       = 8;
  localparam int NO_WIN       = -1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  typedef logic [MAX_WR-1:0][MAX_AW-1:0] wr_addr_vec_t;

  // Highest enabled port whose address matches wins; NO_WIN when none match.
  function automatic int win_port(input logic [MAX_WR-1:0] en,
                                  input wr_addr_vec_t      addr,
                                  input logic [MAX_AW-1:0] a);
    int w;
    w = NO_WIN;
    for (int j = 0; j < MAX_WR; j++) begin
      if (en[j] && (addr[j] == a)) w = j;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the multi-port register file.
// Reads and pending lookups are combinational; no backpressure anywhere.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int AW       = $clog2(NUM_REGS)
);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pending;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   sb_set_en;
  logic [AW-1:0]          sb_set_addr;
  logic                   clear_req;
  logic                   clear_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clear_req,
    input  rd_data, rd_pending, clear_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clear_req,
    output rd_data, rd_pending, clear_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for multi-cycle producers; lookup is combinational,
// updates land on the next edge and a same-cycle set beats any clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr_i,
  input  logic                         set_en_i,
  input  logic [AW-1:0]                set_addr_i,
  input  logic                         clr_en_i,
  input  logic [AW-1:0]                clr_idx_i,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0]            rd_pending_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j]) pend_d[wr_addr_i[j]] = 1'b0;
    end
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    // A new producer supersedes the one whose result is landing now.
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    rd_pending_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_pending_o[i] = pend_q[rd_addr_i[i]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hard-wired x0, optional write bypass, pending
// scoreboard and a one-entry-per-cycle clear sweep; reads are combinational.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  logic [NUM_REGS-1:0][XLEN-1:0] mem_q, mem_d;
  clr_state_e                    state_q, state_d;
  logic [AW-1:0]                 idx_q, idx_d;

  logic                          sweep;
  logic [NUM_WR-1:0]             wen_eff;
  logic                          sb_set_eff;
  logic [NUM_WR-1:0][AW-1:0]     wa;
  logic [NUM_WR-1:0][XLEN-1:0]   wd;
  logic [NUM_RD-1:0][AW-1:0]     ra;
  logic [NUM_RD-1:0][XLEN-1:0]   rd_dat;
  logic [NUM_RD-1:0]             rd_pend;
  logic [MAX_WR-1:0]             wen_pad;
  wr_addr_vec_t                  wa_pad;

  assign sweep      = (state_q == SWEEP);
  assign wa         = bus.wr_addr;
  assign wd         = bus.wr_data;
  assign ra         = bus.rd_addr;
  assign wen_eff    = sweep ? '0 : bus.wr_en;
  assign sb_set_eff = bus.sb_set_en & ~sweep;

  // Writes to x0 are dropped here so neither the array nor bypass can see them.
  always_comb begin
    wen_pad = '0;
    wa_pad  = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wen_pad[j] = wen_eff[j] && (wa[j] != '0);
      wa_pad[j]  = MAX_AW'(wa[j]);
    end
  end

  always_comb begin : p_read
    int w;
    w      = NO_WIN;
    rd_dat = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_dat[i] = mem_q[ra[i]];
      w = win_port(wen_pad, wa_pad, MAX_AW'(ra[i]));
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w == j) rd_dat[i] = wd[j];
        end
      end
    end
  end

  assign bus.rd_data    = rd_dat;
  assign bus.rd_pending = rd_pend;
  assign bus.clear_busy = sweep;

  always_comb begin : p_fsm
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = SWEEP;
          idx_d   = AW'(1);
        end
      end
      SWEEP: begin
        if (idx_q == AW'(NUM_REGS - 1)) begin
          state_d = IDLE;
          idx_d   = AW'(1);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = AW'(1);
      end
    endcase
  end

  always_comb begin : p_mem
    int w;
    w     = NO_WIN;
    mem_d = mem_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      w = win_port(wen_pad, wa_pad, MAX_AW'(r));
      for (int j = 0; j < NUM_WR; j++) begin
        if (w == j) mem_d[r] = wd[j];
      end
    end
    if (sweep) mem_d[idx_q] = '0;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      state_q <= IDLE;
      idx_q   <= AW'(1);
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (wen_pad[NUM_WR-1:0]),
    .wr_addr_i    (wa),
    .set_en_i     (sb_set_eff),
    .set_addr_i   (bus.sb_set_addr),
    .clr_en_i     (sweep),
    .clr_idx_i    (idx_q),
    .rd_addr_i    (ra),
    .rd_pending_o (rd_pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: per-cycle vector table on a bypassing instance,
// plus hand sequences for no-bypass timing, the clear sweep and mid-sweep reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;
  localparam int AW       = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) ifa ();
  regfile_mp_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) ifb ();

  regfile_mp #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  regfile_mp #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct packed {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        sb;
    logic [4:0]  sba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ep;
  } vec_t;

  vec_t vt [12];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.sb_set_en = 1'b0; ifa.sb_set_addr = '0; ifa.clear_req = 1'b0;
  endtask

  task automatic idle_b();
    ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.sb_set_en = 1'b0; ifb.sb_set_addr = '0; ifb.clear_req = 1'b0;
    ifb.rd_addr = '0;
  endtask

  function automatic logic [31:0] fillv(input int r);
    return 32'hC000_0000 | 32'(r);
  endfunction

  task automatic fill_a();
    for (int r = 1; r < NUM_REGS; r += 2) begin
      ifa.wr_en   = (r + 1 < NUM_REGS) ? 2'b11 : 2'b01;
      ifa.wr_addr = {AW'(r + 1), AW'(r)};
      ifa.wr_data = {fillv(r + 1), fillv(r)};
      @(posedge clk); #1;
    end
    idle_a();
  endtask

  initial begin
    int cnt;

    vt[0]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31, 32'h0, 32'h0, 2'b00};
    vt[1]  = '{2'b11, 5'd3, 32'h11111111, 5'd3, 32'h22222222, 1'b0, 5'd0, 5'd3, 5'd0, 32'h22222222, 32'h0, 2'b00};
    vt[2]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h22222222, 32'h22222222, 2'b00};
    vt[3]  = '{2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3, 32'hDEADBEEF, 32'h22222222, 2'b00};
    vt[4]  = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd7, 32'h0, 32'hDEADBEEF, 2'b00};
    vt[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vt[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0, 2'b00};
    vt[7]  = '{2'b01, 5'd9, 32'h12345678, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 2'b11};
    vt[8]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd3, 32'hA5A5A5A5, 32'h22222222, 2'b01};
    vt[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00};
    vt[10] = '{2'b11, 5'd4, 32'h00000044, 5'd5, 32'h00000055, 1'b0, 5'd0, 5'd4, 5'd5, 32'h44, 32'h55, 2'b00};
    vt[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd4, 32'h55, 32'h44, 2'b00};

    reset = 1'b1;
    idle_a(); idle_b();
    ifa.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // No-bypass instance: old value during the write cycle, new value after.
    ifb.wr_en = 2'b01; ifb.wr_addr = {5'd0, 5'd7}; ifb.wr_data = {32'h0, 32'hDEADBEEF};
    ifb.rd_addr = {5'd0, 5'd7};
    @(negedge clk);
    chk("nobyp_same_cycle", ifb.rd_data[31:0], 32'h0);
    @(posedge clk); #1;
    ifb.wr_en = '0;
    @(negedge clk);
    chk("nobyp_next_cycle", ifb.rd_data[31:0], 32'hDEADBEEF);
    chk("reset_busy", {31'd0, ifa.clear_busy}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      ifa.wr_en       = vt[k].wen;
      ifa.wr_addr     = {vt[k].wa1, vt[k].wa0};
      ifa.wr_data     = {vt[k].wd1, vt[k].wd0};
      ifa.sb_set_en   = vt[k].sb;
      ifa.sb_set_addr = vt[k].sba;
      ifa.rd_addr     = {vt[k].ra1, vt[k].ra0};
      @(negedge clk);
      chk($sformatf("row%0d_rd0", k), ifa.rd_data[31:0], vt[k].e0);
      chk($sformatf("row%0d_rd1", k), ifa.rd_data[63:32], vt[k].e1);
      chk($sformatf("row%0d_pend", k), {30'd0, ifa.rd_pending}, {30'd0, vt[k].ep});
      @(posedge clk); #1;
    end
    idle_a();

    // First sweep: fill, claim x25, pulse clear_req.
    fill_a();
    ifa.sb_set_en = 1'b1; ifa.sb_set_addr = 5'd25;
    @(posedge clk); #1;
    idle_a();
    ifa.rd_addr = {5'd25, 5'd17};
    @(negedge clk);
    chk("fill_x17", ifa.rd_data[31:0], fillv(17));
    chk("pend_x25_before", {31'd0, ifa.rd_pending[1]}, 32'd1);
    @(posedge clk); #1;
    ifa.clear_req = 1'b1;
    @(posedge clk); #1;
    ifa.clear_req = 1'b0;
    cnt = 0;
    while (ifa.clear_busy && cnt < 100) begin
      cnt++;
      idle_a();
      if (cnt == 5) begin
        ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd1}; ifa.wr_data = {32'h0, 32'h0BAD0BAD};
        ifa.sb_set_en = 1'b1; ifa.sb_set_addr = 5'd1;
        ifa.rd_addr = {5'd0, 5'd1};
      end
      if (cnt == 10) ifa.clear_req = 1'b1;
      @(negedge clk);
      if (cnt == 5) chk("sweep_no_bypass", ifa.rd_data[31:0], 32'h0);
      @(posedge clk); #1;
    end
    idle_a();
    chk("sweep_busy_cycles", 32'(cnt), 32'd31);

    for (int r = 1; r < NUM_REGS; r++) begin
      ifa.rd_addr = {AW'(0), AW'(r)};
      @(negedge clk);
      chk($sformatf("swept_x%0d", r), ifa.rd_data[31:0], 32'h0);
      chk($sformatf("swept_pend_x%0d", r), {31'd0, ifa.rd_pending[0]}, 32'd0);
      @(posedge clk); #1;
    end

    // Second sweep aborted by reset at sweep cycle 10.
    fill_a();
    ifa.sb_set_en = 1'b1; ifa.sb_set_addr = 5'd20;
    @(posedge clk); #1;
    idle_a();
    ifa.clear_req = 1'b1;
    @(posedge clk); #1;
    ifa.clear_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    ifa.rd_addr = {5'd20, 5'd31};
    @(negedge clk);
    chk("mid_busy", {31'd0, ifa.clear_busy}, 32'd1);
    chk("mid_x31_untouched", ifa.rd_data[31:0], fillv(31));
    chk("mid_pend_x20", {31'd0, ifa.rd_pending[1]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, ifa.clear_busy}, 32'd0);
    chk("rst_x31", ifa.rd_data[31:0], 32'h0);
    chk("rst_x20", ifa.rd_data[63:32], 32'h0);
    chk("rst_pend_x20", {31'd0, ifa.rd_pending[1]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, ifa.clear_busy}, 32'd0);
    chk("post_rst_x31", ifa.rd_data[31:0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write/dual-read register file in the RV32I core. It adds:
- configurable read and write port counts;
- a hard-wired x0;
- optional write-to-read bypass;
- a per-register pending scoreboard for multi-cycle producers such as loads;
- a sequential clear engine that zeroes the array without asserting reset.

It sits between decode (read addresses) and writeback (write ports).

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports; a higher port index has priority.
- BYPASS, 1, 1 means same-cycle write data is forwarded to a matching read port.
- AW, $clog2(NUM_REGS), address width (derived; do not override).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- rd_addr  input  NUM_RD*AW  packed read addresses; port i is at [i*AW +: AW]
- rd_data  output  NUM_RD*XLEN  packed read data
- rd_pending  output  NUM_RD  scoreboard bit of each read address
- wr_en  input  NUM_WR  per-port write enable
- wr_addr  input  NUM_WR*AW  packed write addresses
- wr_data  input  NUM_WR*XLEN  packed write data
- sb_set_en  input  1  mark sb_set_addr as pending
- sb_set_addr  input  AW  register being claimed by a multi-cycle producer
- clear_req  input  1  single-cycle pulse that starts a clear sweep
- clear_busy  output  1  high while the clear sweep runs

Behaviour:
- Reset (asynchronous, active-high):
  - all NUM_REGS entries go to 0 and all pending bits go to 0;
  - clear FSM goes to IDLE and its index goes to 1;
  - clear_busy = 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- Register 0:
  - always reads 0 and is never pending;
  - writes and sb_set targeting address 0 are discarded.
- Reads are combinational:
  - rd_data[i] = array[rd_addr[i]];
  - if BYPASS = 1 and any wr_en[j] is high with wr_addr[j] = rd_addr[i] != 0, rd_data[i] = wr_data of the highest such j;
  - if BYPASS = 0, new data is visible the cycle after the write edge.
- Writes:
  - on posedge clk, every enabled port with a nonzero address updates its entry;
  - if several ports target the same address, the highest port index wins.
- Scoreboard:
  - on posedge clk, an accepted write to address a clears pending[a];
  - sb_set_en with a nonzero address sets pending[sb_set_addr];
  - set and clear of the same address in the same cycle: set wins, because the new producer supersedes the old one;
  - rd_pending[i] = pending[rd_addr[i]];
  - there is no bypass on pending: a clear is seen the next cycle.
- Clear FSM, with states IDLE and SWEEP and an index register idx:
  - IDLE: clear_req moves to SWEEP with idx = 1; clear_busy goes high the cycle after clear_req.
  - SWEEP: each cycle, array[idx] = 0 and pending[idx] = 0, then idx increments.
  - After idx = NUM_REGS-1 is cleared, go to IDLE and reset idx to 1.
  - A sweep takes NUM_REGS-1 cycles.
  - clear_req while in SWEEP is ignored; the sweep does not restart.
  - During SWEEP, wr_en and sb_set_en are ignored (writes dropped).
  - Reads stay live during SWEEP, and bypass is suppressed.
- Every address is AW bits wide and every entry is addressable, so no out-of-range condition exists.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NUM_REGS constants;
  - the clear FSM state enum (IDLE, SWEEP);
  - a helper function that returns the winning write-port index for an address, or no match.
- One natural sub-module, regfile_scoreboard, holds the pending bit-vector with its set/clear priority and per-port lookup.
- The clear FSM and the data array stay in the top module.

Test Plan:
1. Reset then read: assert reset, release; read x5 and x31 -> 0, rd_pending = 0, clear_busy = 0.
2. Dual write with conflict: port0 writes x3 = 0x11111111 and port1 writes x3 = 0x22222222 in the same cycle -> next cycle x3 reads 0x22222222.
3. Bypass: BYPASS = 1, write x7 = 0xDEADBEEF while reading x7 in the same cycle -> rd_data = 0xDEADBEEF that cycle. With BYPASS = 0 -> old value that cycle, new value the next cycle.
4. x0 rules: write x0 = 0xFFFFFFFF and sb_set x0 -> x0 still reads 0 with rd_pending = 0.
5. Scoreboard: sb_set x9 -> rd_pending = 1 the next cycle. Then same-cycle write x9 plus sb_set x9 -> pending stays 1. Then write x9 alone -> pending = 0 the next cycle.
6. Clear sweep plus mid-sweep reset:
   - fill x1..x31 with nonzero values, pulse clear_req -> clear_busy high for 31 cycles, all entries read 0 afterwards, a write issued during the sweep is dropped;
   - repeat the sweep and assert reset at sweep cycle 10 -> all entries 0 and clear_busy = 0 immediately.
